// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output in_valid, minuend, subtrahend, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    modport slave (
        input  in_valid, minuend, subtrahend, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one subtract cell plus a borrow flop, LSB first,
// WIDTH cycles per operation, valid/ready handshake on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             borrow_out_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic [WIDTH-1:0] diff_sh_s;
    logic [1:0]       cell_s;

    // One full-subtract cell: returns {borrow_next, diff_bit}.
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bin);
        logic d;
        logic bn;
        d  = a ^ b ^ bin;
        bn = (~a & b) | (~(a ^ b) & bin);
        return {bn, d};
    endfunction

    // Handshake flags come straight from the state register.
    assign bus.in_ready   = (state_r == IDLE);
    assign bus.out_valid  = (state_r == DONE);
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;

    // Next-state decode and the serial datapath step.
    always_comb begin
        state_s   = state_r;
        cell_s    = sub_cell(a_r[0], b_r[0], borrow_r);
        a_sh_s    = a_r >> 1'b1;
        b_sh_s    = b_r >> 1'b1;
        diff_sh_s = diff_sh_r >> 1'b1;
        diff_sh_s[WIDTH-1] = cell_s[0];
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_s = BUSY;
                else              state_s = IDLE;
            end
            BUSY: begin
                if (count_r == LAST) state_s = DONE;
                else                 state_s = BUSY;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand shift registers, borrow chain and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            diff_sh_r    <= '0;
            diff_r       <= '0;
            borrow_r     <= 1'b0;
            borrow_out_r <= 1'b0;
            count_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r       <= bus.minuend;
                        b_r       <= bus.subtrahend;
                        diff_sh_r <= '0;
                        borrow_r  <= 1'b0;
                        count_r   <= '0;
                    end
                end
                BUSY: begin
                    a_r       <= a_sh_s;
                    b_r       <= b_sh_s;
                    diff_sh_r <= diff_sh_s;
                    borrow_r  <= cell_s[1];
                    count_r   <= count_r + CW'(1);
                    // Result is published only once the last bit is in.
                    if (count_r == LAST) begin
                        diff_r       <= diff_sh_s;
                        borrow_out_r <= cell_s[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) if8();
    serial_subtractor_if #(.WIDTH(1)) if1();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair to the 8-bit unit and check result and latency.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic drain);
        int w;
        int cyc;
        if8.minuend    = a;
        if8.subtrahend = b;
        if8.in_valid   = 1'b1;
        if8.out_ready  = drain;
        w = 0;
        while (!if8.in_ready && w < 100) begin tick(); w++; end
        chk({tag, "_accept"}, 32'(if8.in_ready), 32'd1);
        tick();
        if8.in_valid = 1'b0;
        cyc = 1;
        while (!if8.out_valid && cyc < 100) begin tick(); cyc++; end
        chk({tag, "_latency"}, 32'(cyc), 32'd9);
        chk({tag, "_diff"},    32'(if8.diff), 32'(ed));
        chk({tag, "_borrow"},  32'(if8.borrow_out), 32'(eb));
        if (drain) begin
            tick();
            chk({tag, "_ov_drop"}, 32'(if8.out_valid), 32'd0);
            chk({tag, "_ir_back"}, 32'(if8.in_ready), 32'd1);
        end
    endtask

    // Same for the 1-bit unit: one BUSY cycle.
    task automatic run1(input string tag, input logic a, input logic b,
                        input logic ed, input logic eb);
        int cyc;
        if1.minuend    = a;
        if1.subtrahend = b;
        if1.in_valid   = 1'b1;
        if1.out_ready  = 1'b1;
        chk({tag, "_accept"}, 32'(if1.in_ready), 32'd1);
        tick();
        if1.in_valid = 1'b0;
        cyc = 1;
        while (!if1.out_valid && cyc < 100) begin tick(); cyc++; end
        chk({tag, "_latency"}, 32'(cyc), 32'd2);
        chk({tag, "_diff"},    32'(if1.diff), 32'(ed));
        chk({tag, "_borrow"},  32'(if1.borrow_out), 32'(eb));
        tick();
    endtask

    initial begin
        logic [7:0] cur_a;
        logic [7:0] cur_b;
        logic [8:0] ref_r;
        logic [8:0] q[$];
        logic       acc;
        logic       take;
        int         sent;
        int         got;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.minuend = 8'h00; if8.subtrahend = 8'h00; if8.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.minuend = 1'b0;  if1.subtrahend = 1'b0;  if1.out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  32'(if8.in_ready),   32'd1);
        chk("rst_out_valid", 32'(if8.out_valid),  32'd0);
        chk("rst_diff",      32'(if8.diff),       32'd0);
        chk("rst_borrow",    32'(if8.borrow_out), 32'd0);
        chk("rst_w1_ready",  32'(if1.in_ready),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T1 / T2: basic arithmetic and boundaries
        run8("t1",   8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b1);
        run8("t2a",  8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
        run8("t2b",  8'h80, 8'h80, 8'h00, 1'b0, 1'b1);
        run8("t2c",  8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1);

        // T3: backpressure in DONE while in_valid pulses
        run8("t3", 8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if8.in_valid   = ~if8.in_valid;
            if8.minuend    = 8'h11;
            if8.subtrahend = 8'h22;
            tick();
            chk("t3_ov_hold",  32'(if8.out_valid),  32'd1);
            chk("t3_ir_low",   32'(if8.in_ready),   32'd0);
            chk("t3_diff",     32'(if8.diff),       32'h4B);
            chk("t3_borrow",   32'(if8.borrow_out), 32'd0);
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        chk("t3_ov_drop",   32'(if8.out_valid), 32'd0);
        chk("t3_ir_back",   32'(if8.in_ready),  32'd1);
        chk("t3_diff_keep", 32'(if8.diff),      32'h4B);

        // T4: reset four cycles into BUSY
        if8.minuend = 8'hFF; if8.subtrahend = 8'h01; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        repeat (4) tick();
        chk("t4_busy", 32'(if8.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t4_ov",     32'(if8.out_valid),  32'd0);
        chk("t4_ir",     32'(if8.in_ready),   32'd1);
        chk("t4_diff",   32'(if8.diff),       32'd0);
        chk("t4_borrow", 32'(if8.borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run8("t4_next", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b1);

        // T5: WIDTH=1 half-subtractor truth table
        run1("t5_00", 1'b0, 1'b0, 1'b0, 1'b0);
        run1("t5_01", 1'b0, 1'b1, 1'b1, 1'b1);
        run1("t5_11", 1'b1, 1'b1, 1'b0, 1'b0);
        run1("t5_10", 1'b1, 1'b0, 1'b1, 1'b0);

        // T6: random back-to-back traffic against a 9-bit reference subtract
        sent = 0;
        got  = 0;
        cur_a = 8'h00;
        cur_b = 8'h00;
        if8.in_valid = 1'b0;
        for (int c = 0; c < 40000 && got < 1000; c++) begin
            if8.out_ready = 1'($urandom_range(0, 1));
            if (!if8.in_valid && sent < 1000) begin
                cur_a = 8'($urandom);
                cur_b = 8'($urandom);
                if8.minuend    = cur_a;
                if8.subtrahend = cur_b;
                if8.in_valid   = 1'b1;
            end
            acc  = if8.in_valid && if8.in_ready;
            take = if8.out_valid && if8.out_ready;
            if (take) begin
                chk("t6_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    ref_r = q.pop_front();
                    chk("t6_diff",   32'(if8.diff),       32'(ref_r[7:0]));
                    chk("t6_borrow", 32'(if8.borrow_out), 32'(ref_r[8]));
                end
                got++;
            end
            tick();
            if (acc) begin
                q.push_back({1'b0, cur_a} - {1'b0, cur_b});
                sent++;
                if8.in_valid = 1'b0;
            end
        end
        chk("t6_count", 32'(got),      32'd1000);
        chk("t6_left",  32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
